kuznechik_cipher_core: RTL
==========================

// Module: kuznechik_cipher_core
// PURPOSE
//  Parametrised GOST R 34.12-2015 (Kuznechik) block-cipher core with encrypt and decrypt modes.
//  Adds valid/ready handshakes and a configurable L-layer unroll.
//  Sits between the key-schedule block (supplies 10 round keys) and the stream/mode logic.
//  Instances table_convertion (pi) for encryption and table_convertion_inv (pi^-1) for decryption.
// PARAMETERS
//  L_STEPS_PER_CYCLE  1  R-steps (or R^-1-steps) done per clock; legal 1,2,4,8,16, other values = elaboration error
//  ENABLE_DECRYPT     1  0: inverse S/L hardware not built; in_mode ignored; every block is encrypted
// PORTS
//  clk         in   1     clock; all logic on posedge
//  rst_n       in   1     asynchronous, active-low reset
//  in_valid    in   1     input block valid
//  in_ready    out  1     core idle and able to accept a block
//  in_mode     in   1     0 = encrypt, 1 = decrypt; sampled at accept
//  in_word     in   128   plaintext/ciphertext; byte a15 = [127:120]
//  round_keys  in   1280  K1 at [127:0] ... K10 at [1279:1152]; sampled at accept
//  out_valid   out  1     result valid; held until accepted
//  out_ready   in   1     downstream accepts result
//  out_word    out  128   result block
//  busy        out  1     1 from accept until the output handshake completes
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, out_valid=0, out_word=0, busy=0, round counter=0, internal word/keys=0.
//  Accept: in_valid & in_ready on a posedge. Latches in_word, all 10 keys and mode. busy=1.
//  FSM states:
//   IDLE: in_ready=1; go to FIRST on accept.
//   FIRST: enc -> X[K1]; dec -> X[K10].
//   Then 9 rounds, r = 1..9:
//    - enc round: SUB(pi), LIN (16/N cycles of R), XOR K(r+1).
//    - dec round: LIN (16/N cycles of R^-1), SUB(pi^-1), XOR K(10-r).
//   The last XOR writes out_word and sets out_valid=1; go to DONE.
//   DONE: hold out_word and out_valid until out_ready=1, then clear out_valid and busy; go to IDLE.
//  in_ready=1 only in IDLE, including during reset. in_valid is ignored in every other state.
//  N = L_STEPS_PER_CYCLE. Latency from accept edge to out_valid high is 1 + 9*(2 + 16/N) cycles.
//   N=1: 163 cycles; N=16: 28 cycles. Encrypt and decrypt latency are identical.
//  R(a15..a0)    = l(a15..a0) || a15..a1.
//  R^-1(a15..a0) = a14..a0 || l(a14..a0, a15).
//  l = 148*a15 ^ 32*a14 ^ 133*a13 ^ 16*a12 ^ 194*a11 ^ 192*a10 ^ 1*a9 ^ 251*a8 ^ 1*a7 ^ 192*a6
//      ^ 194*a5 ^ 16*a4 ^ 133*a3 ^ 32*a2 ^ 148*a1 ^ 1*a0.
//   All products in GF(2^8) modulo x^8+x^7+x^6+x+1 (0x1C3).
//   The N chained steps are combinational within one cycle.
//  The round counter is 4 bits and never wraps; FSM leaves the round loop exactly at r=9.
//  No input queueing: a second block waits on in_ready. out_ready high in a non-DONE state has no effect.
//  Changing in_word, round_keys or in_mode after accept does not affect the block in flight.
//  rst_n low mid-operation aborts the block; nothing is output. A new block is accepted 1 cycle after release.
// TESTING
//  Common data (GOST A.1 vector):
//   K1..K10 = 8899aabbccddeeff0011223344556677, fedcba98765432100123456789abcdef,
//    db31485315694343228d6aef8cc78c44, 3d4553d8e9cfec6815ebadc40a9ffd04, 57646468c44a5e28d3e59246f429f1ac,
//    bd079435165c6432b532e82834da581b, 51e640757e8745de705727265a0098b1, 5a7925017b9fdd3ed72a91a22286f984,
//    bb44e25378c73123a5f32f73cdb6e517, 72e9dd7416bcf45b755dbaa88e4a4043.
//   P = 1122334455667700ffeeddccbbaa9988, C = 7f679d90bebc24305a468d42b9d4edcd.
//  Scenarios:
//  1. N=1, mode=0, in_word=P, out_ready=1 -> out_valid rises exactly 163 cycles after accept, out_word=C.
//  2. N=1, mode=1, in_word=C -> out_word=P after 163 cycles.
//  3. N=16, enc then dec back-to-back -> C then P, each 28 cycles after accept.
//  4. Backpressure: out_ready=0 for 20 cycles after out_valid -> out_word stays C, in_ready=0, a new in_valid is not accepted.
//     Then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 on the next cycle.
//  5. Reset mid-run: rst_n=0 at cycle 50 of a run -> out_valid=0 and out_word=0 immediately, in_ready=1.
//     After release, P encrypts to C.
//  6. ENABLE_DECRYPT=0, mode=1, in_word=P -> out_word=C.
//     Keys and in_word changed to random values 1 cycle after accept -> result still C.

Source files
------------

// File: rtl/kuznechik_cipher_core.sv
// Kuznechik (GOST R 34.12-2015) iterative block cipher core with encrypt/decrypt,
// valid/ready handshakes and an L_STEPS_PER_CYCLE-wide unrolled linear layer.

// Bytewise substitution through a 256-entry table (entry 0 in the top byte).
module table_convertion #(
  parameter logic [2047:0] TABLE = '0
) (
  input  logic [127:0] src,
  output logic [127:0] dst
);
  always_comb begin
    dst = '0;
    for (int i = 0; i < 16; i++)
      dst[8*i +: 8] = TABLE[8*(255 - int'(src[8*i +: 8])) +: 8];
  end
endmodule

// Inverse substitution; the inverse table is derived from the forward one at elaboration.
module table_convertion_inv #(
  parameter logic [2047:0] TABLE = '0
) (
  input  logic [127:0] src,
  output logic [127:0] dst
);
  function automatic logic [2047:0] invert(input logic [2047:0] t);
    logic [2047:0] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      r[8*(255 - int'(t[8*(255 - i) +: 8])) +: 8] = 8'(i);
    return r;
  endfunction

  localparam logic [2047:0] INV_TABLE = invert(TABLE);

  always_comb begin
    dst = '0;
    for (int i = 0; i < 16; i++)
      dst[8*i +: 8] = INV_TABLE[8*(255 - int'(src[8*i +: 8])) +: 8];
  end
endmodule

module kuznechik_cipher_core #(
  parameter int L_STEPS_PER_CYCLE = 1,
  parameter bit ENABLE_DECRYPT    = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [127:0]  in_word,
  input  logic [1279:0] round_keys,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_word,
  output logic          busy
);
  localparam logic [2047:0] PI_TABLE = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6};

  // l() coefficients, byte i multiplies a_i
  localparam logic [127:0] L_COEF     = 128'h942085_10C2C001FB01C0C2108520_9401;
  localparam int           LIN_CYCLES = 16 / L_STEPS_PER_CYCLE;
  localparam logic [3:0]   LIN_LAST   = 4'(LIN_CYCLES - 1);

  if (L_STEPS_PER_CYCLE != 1 && L_STEPS_PER_CYCLE != 2 && L_STEPS_PER_CYCLE != 4 &&
      L_STEPS_PER_CYCLE != 8 && L_STEPS_PER_CYCLE != 16) begin : g_bad_steps
    $error("L_STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] l_func(input logic [127:0] a);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc ^= gf_mul(a[8*i +: 8], L_COEF[8*i +: 8]);
    return acc;
  endfunction

  function automatic logic [127:0] lin_fwd(input logic [127:0] a);
    logic [127:0] w;
    w = a;
    for (int s = 0; s < L_STEPS_PER_CYCLE; s++) w = {l_func(w), w[127:8]};
    return w;
  endfunction

  function automatic logic [127:0] lin_bwd(input logic [127:0] a);
    logic [127:0] w;
    w = a;
    for (int s = 0; s < L_STEPS_PER_CYCLE; s++) w = {w[119:0], l_func({w[119:0], w[127:120]})};
    return w;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_SUB, S_LIN, S_XOR, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     round_q, lin_cnt_q, key_idx;
  logic           mode_q;
  logic [127:0]   word_q, round_key, sub_fwd, sub_inv, lin_inv, sub_out, lin_out;
  logic [1279:0]  keys_q;

  table_convertion #(.TABLE(PI_TABLE)) u_pi (.src(word_q), .dst(sub_fwd));

  if (ENABLE_DECRYPT) begin : g_dec
    table_convertion_inv #(.TABLE(PI_TABLE)) u_pi_inv (.src(word_q), .dst(sub_inv));
    assign lin_inv = lin_bwd(word_q);
  end else begin : g_no_dec
    assign sub_inv = '0;
    assign lin_inv = '0;
  end

  // Encryption walks K1..K10, decryption walks K10..K1
  always_comb begin
    key_idx = 4'd0;
    if (state_q == S_XOR) key_idx = mode_q ? (4'd9 - round_q) : round_q;
    else if (mode_q)      key_idx = 4'd9;
    round_key = keys_q[128*key_idx +: 128];
    sub_out   = mode_q ? sub_inv : sub_fwd;
    lin_out   = mode_q ? lin_inv : lin_fwd(word_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_FIRST;
      S_FIRST: state_d = mode_q ? S_LIN : S_SUB;
      S_SUB:   state_d = mode_q ? S_XOR : S_LIN;
      S_LIN:   if (lin_cnt_q == LIN_LAST) state_d = mode_q ? S_SUB : S_XOR;
      S_XOR:   state_d = (round_q == 4'd9) ? S_DONE : (mode_q ? S_LIN : S_SUB);
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      keys_q    <= '0;
      mode_q    <= 1'b0;
      round_q   <= '0;
      lin_cnt_q <= '0;
      out_word  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          word_q    <= in_word;
          keys_q    <= round_keys;
          mode_q    <= ENABLE_DECRYPT & in_mode;
          round_q   <= '0;
          lin_cnt_q <= '0;
        end
        S_FIRST: begin
          word_q  <= word_q ^ round_key;
          round_q <= 4'd1;
        end
        S_SUB: word_q <= sub_out;
        S_LIN: begin
          word_q    <= lin_out;
          lin_cnt_q <= (lin_cnt_q == LIN_LAST) ? 4'd0 : lin_cnt_q + 4'd1;
        end
        S_XOR: begin
          word_q <= word_q ^ round_key;
          if (round_q == 4'd9) out_word <= word_q ^ round_key;
          else                 round_q  <= round_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
endmodule
